pc_sequencer: RTL and testbench

Parametrised program-counter and return-stack unit for the PUC CPU family, replacing the fixed-width inline PC/stack logic of the core. It computes the next PC from a decoded sequencing op (next, jump, conditional jump, call, exit, halt), and keeps a return stack of configurable depth with overflow and underflow detection. It also supports pipeline stall and halt/resume. It sits between the instruction decoder and the instruction memory address port.

---
 rtl/pc_sequencer.sv | 139 +++++++++++++
 tb/tb_pc_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and return stack for the PUC CPU family.
// Computes the next PC from a decoded sequencing op, maintains a return stack
// with overflow/underflow detection, and supports stall and halt/resume.
//
// Handshake note: there is no valid/ready pair here. op/target/accumulatorZero
// and resume are sampled on every posedge where stall=0, and every effect is
// visible after that edge (one cycle latency).
module pc_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 16,
    localparam int PTR_WIDTH  = $clog2(STACK_DEPTH)
) (
    input  logic                 clock,
    input  logic                 isReset,
    input  logic                 stall,
    input  logic [2:0]           op,
    input  logic [PC_WIDTH-1:0]  target,
    input  logic                 accumulatorZero,
    input  logic                 resume,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [PTR_WIDTH:0]   depth,
    output logic [PC_WIDTH-1:0]  returnAddress,
    output logic                 halted,
    output logic                 overflow,
    output logic                 underflow,
    output logic [1:0]           debugState
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    localparam logic [2:0] OP_NEXT  = 3'd0;
    localparam logic [2:0] OP_JUMP  = 3'd1;
    localparam logic [2:0] OP_JZ    = 3'd2;
    localparam logic [2:0] OP_JNZ   = 3'd3;
    localparam logic [2:0] OP_CALL  = 3'd4;
    localparam logic [2:0] OP_EXIT  = 3'd5;
    localparam logic [2:0] OP_HALT  = 3'd6;

    localparam logic [PTR_WIDTH:0] DEPTH_FULL = (PTR_WIDTH+1)'(STACK_DEPTH);

    state_t                state, state_next;
    logic [PC_WIDTH-1:0]   pc_next;
    logic [PTR_WIDTH:0]    depth_next;
    logic                  overflow_next, underflow_next;
    logic                  push_en;
    logic [PC_WIDTH-1:0]   pc_inc;
    logic [PTR_WIDTH-1:0]  push_idx;
    logic [PTR_WIDTH-1:0]  top_idx;

    logic [PC_WIDTH-1:0]   stack_mem [STACK_DEPTH];

    // pc+1 wraps naturally at the register width; it is also the pushed return address.
    assign pc_inc   = pc + 1'b1;
    assign push_idx = PTR_WIDTH'(depth);
    assign top_idx  = PTR_WIDTH'(depth - 1'b1);

    assign returnAddress = (depth == '0) ? '0 : stack_mem[top_idx];
    assign halted        = (state == ST_HALTED);
    assign debugState    = state;

    // Next-state / next-value logic; stall leaves every default (hold) in place.
    always_comb begin
        state_next     = state;
        pc_next        = pc;
        depth_next     = depth;
        overflow_next  = overflow;
        underflow_next = underflow;
        push_en        = 1'b0;
        if (!stall) begin
            case (state)
                ST_RUN: begin
                    case (op)
                        OP_JUMP: pc_next = target;
                        OP_JZ:   pc_next = accumulatorZero ? target : pc_inc;
                        OP_JNZ:  pc_next = accumulatorZero ? pc_inc : target;
                        OP_CALL: begin
                            if (depth == DEPTH_FULL) begin
                                overflow_next = 1'b1;
                                state_next    = ST_FAULT;
                            end else begin
                                push_en    = 1'b1;
                                depth_next = depth + 1'b1;
                                pc_next    = target;
                            end
                        end
                        OP_EXIT: begin
                            if (depth == '0) begin
                                underflow_next = 1'b1;
                                state_next     = ST_FAULT;
                            end else begin
                                pc_next    = stack_mem[top_idx];
                                depth_next = depth - 1'b1;
                            end
                        end
                        OP_HALT: state_next = ST_HALTED;
                        default: pc_next = pc_inc;  // NEXT and reserved
                    endcase
                end
                ST_HALTED: begin
                    if (resume) begin
                        pc_next    = pc_inc;
                        state_next = ST_RUN;
                    end
                end
                ST_FAULT: ;
                default: state_next = ST_FAULT;
            endcase
        end
    end

    // Control registers: reset has priority over everything, including stall.
    always_ff @(posedge clock) begin
        if (isReset) begin
            state     <= ST_RUN;
            pc        <= '0;
            depth     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            depth     <= depth_next;
            overflow  <= overflow_next;
            underflow <= underflow_next;
        end
    end

    // Stack storage is never cleared; entries above depth are unobservable.
    always_ff @(posedge clock) begin
        if (!isReset && push_en) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test-plan sequences followed by random ops,
// checked every cycle against a queue-based behavioural model.
module tb_pc_sequencer;

    localparam int PC_WIDTH    = 8;
    localparam int STACK_DEPTH = 4;
    localparam int PTR_WIDTH   = $clog2(STACK_DEPTH);

    logic                 clock = 1'b0;
    logic                 isReset = 1'b1;
    logic                 stall = 1'b0;
    logic [2:0]           op = 3'd0;
    logic [PC_WIDTH-1:0]  target = '0;
    logic                 accumulatorZero = 1'b0;
    logic                 resume = 1'b0;
    logic [PC_WIDTH-1:0]  pc;
    logic [PTR_WIDTH:0]   depth;
    logic [PC_WIDTH-1:0]  returnAddress;
    logic                 halted;
    logic                 overflow;
    logic                 underflow;
    logic [1:0]           debugState;

    int total = 0;
    int bad   = 0;

    // model state: plain integers and a queue used as the return stack
    int   m_pc;
    int   m_mode;   // 0 running, 1 halted, 2 faulted
    bit   m_ovf, m_unf;
    logic [PC_WIDTH-1:0] ret_q[$];

    pc_sequencer #(.PC_WIDTH(PC_WIDTH), .STACK_DEPTH(STACK_DEPTH)) dut (
        .clock(clock), .isReset(isReset), .stall(stall), .op(op),
        .target(target), .accumulatorZero(accumulatorZero), .resume(resume),
        .pc(pc), .depth(depth), .returnAddress(returnAddress), .halted(halted),
        .overflow(overflow), .underflow(underflow), .debugState(debugState)
    );

    // clock / reset block
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // model update for one clock edge, from the op semantics
    task automatic model_step(input int o, input int tgt, input bit az, input bit res,
                              input bit stl, input bit rst);
        if (rst) begin
            m_pc = 0; m_mode = 0; m_ovf = 0; m_unf = 0;
            ret_q.delete();
        end else if (!stl) begin
            if (m_mode == 0) begin
                case (o)
                    1: m_pc = tgt;
                    2: m_pc = az ? tgt : (m_pc + 1) % 256;
                    3: m_pc = !az ? tgt : (m_pc + 1) % 256;
                    4: if (ret_q.size() < STACK_DEPTH) begin
                           ret_q.push_back(PC_WIDTH'((m_pc + 1) % 256));
                           m_pc = tgt;
                       end else begin
                           m_ovf = 1; m_mode = 2;
                       end
                    5: if (ret_q.size() > 0) m_pc = int'(ret_q.pop_back());
                       else begin m_unf = 1; m_mode = 2; end
                    6: m_mode = 1;
                    default: m_pc = (m_pc + 1) % 256;
                endcase
            end else if (m_mode == 1) begin
                if (res) begin m_pc = (m_pc + 1) % 256; m_mode = 0; end
            end
        end
    endtask

    task automatic check_all();
        check_value("pc", 32'(pc), 32'(m_pc));
        check_value("depth", 32'(depth), 32'(ret_q.size()));
        check_value("returnAddress", 32'(returnAddress),
                    ret_q.size() == 0 ? 32'd0 : 32'(ret_q[ret_q.size()-1]));
        check_value("halted", 32'(halted), 32'(m_mode == 1));
        check_value("overflow", 32'(overflow), 32'(m_ovf));
        check_value("underflow", 32'(underflow), 32'(m_unf));
    endtask

    // driver: apply inputs after an edge, clock once, update model, check
    task automatic drive(input int o, input int tgt, input bit az, input bit res,
                         input bit stl, input bit rst);
        op = 3'(o); target = PC_WIDTH'(tgt); accumulatorZero = az;
        resume = res; stall = stl; isReset = rst;
        @(posedge clock);
        #1;
        model_step(o, tgt, az, res, stl, rst);
        check_all();
    endtask

    initial begin
        m_pc = 0; m_mode = 0; m_ovf = 0; m_unf = 0;
        #1;

        // reset, then NEXT steps
        drive(0, 0, 0, 0, 0, 1);
        check_value("tp_reset_pc", 32'(pc), 32'd0);
        check_value("tp_reset_depth", 32'(depth), 32'd0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0);
        check_value("tp_next5_pc", 32'(pc), 32'd5);

        // CALL/EXIT from pc=3
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);
        drive(4, 'h40, 0, 0, 0, 0);
        check_value("tp_call_pc", 32'(pc), 32'h40);
        check_value("tp_call_ra", 32'(returnAddress), 32'h04);
        drive(5, 0, 0, 0, 0, 0);
        check_value("tp_exit_pc", 32'(pc), 32'h04);
        check_value("tp_exit_depth", 32'(depth), 32'd0);

        // conditional jumps
        drive(2, 'h20, 1, 0, 0, 0);
        check_value("tp_jz_pc", 32'(pc), 32'h20);
        drive(3, 'h30, 1, 0, 0, 0);
        check_value("tp_jnz_pc", 32'(pc), 32'h21);

        // overflow and fault hold
        for (int i = 0; i < 4; i++) drive(4, 'h50 + i, 0, 0, 0, 0);
        check_value("tp_full_depth", 32'(depth), 32'd4);
        drive(4, 'h60, 0, 0, 0, 0);
        check_value("tp_ovf", 32'(overflow), 32'd1);
        check_value("tp_ovf_pc", 32'(pc), 32'h53);
        for (int i = 0; i < 4; i++) drive(i, 'h11, 0, 1, 0, 0);
        check_value("tp_fault_pc", 32'(pc), 32'h53);
        drive(1, 'h22, 0, 0, 1, 1);
        check_value("tp_rst_ovf", 32'(overflow), 32'd0);
        check_value("tp_rst_depth", 32'(depth), 32'd0);

        // underflow, then wrap on CALL at the top of the address space
        drive(5, 0, 0, 0, 0, 0);
        check_value("tp_unf", 32'(underflow), 32'd1);
        check_value("tp_unf_pc", 32'(pc), 32'd0);
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 'hFF, 0, 0, 0, 0);
        drive(4, 'h10, 0, 0, 0, 0);
        check_value("tp_wrap_ra", 32'(returnAddress), 32'h00);
        check_value("tp_wrap_pc", 32'(pc), 32'h10);

        // halt and resume
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 7, 0, 0, 0, 0);
        drive(6, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) drive(int'($urandom_range(0, 7)), 'h33, 0, 0, 0, 0);
        check_value("tp_halt_pc", 32'(pc), 32'd7);
        check_value("tp_halt_flag", 32'(halted), 32'd1);
        drive(0, 0, 0, 1, 1, 0);
        check_value("tp_stall_resume", 32'(halted), 32'd1);
        drive(0, 0, 0, 1, 0, 0);
        check_value("tp_resume_pc", 32'(pc), 32'd8);
        check_value("tp_resume_flag", 32'(halted), 32'd0);

        // randomized traffic; resets frequent enough to leave FAULT regularly
        for (int i = 0; i < 3000; i++) begin
            int  o;
            bit  rst, stl, res, az;
            o   = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) o = int'($urandom_range(4, 5));
            rst = ($urandom_range(0, 39) == 0);
            stl = ($urandom_range(0, 7) == 0);
            res = ($urandom_range(0, 5) == 0);
            az  = 1'($urandom_range(0, 1));
            drive(o, int'($urandom_range(0, 255)), az, res, stl, rst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
